// File: rtl/dcache_snoop_responder_pkg.sv
// Shared cache types: word and address-split views plus the snoop
// responder state encoding.
package dcache_snoop_responder_pkg;

  typedef logic [31:0] word_t;

  // Byte address split for the 8-set, 2-word-block dcache.
  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcachef_t;

  // Snoop responder states (fixed encodings kept for legacy visibility).
  typedef logic [2:0] snoop_state_t;
  localparam snoop_state_t IDLE   = 3'd0;
  localparam snoop_state_t LOOKUP = 3'd1;
  localparam snoop_state_t FLUSH0 = 3'd2;
  localparam snoop_state_t FLUSH1 = 3'd3;
  localparam snoop_state_t UPDATE = 3'd4;
  localparam snoop_state_t DONE   = 3'd5;

  // Word address of one half of the block containing addr.
  function automatic word_t flush_addr(input word_t addr, input logic blkoff);
    dcachef_t f;
    f        = dcachef_t'(addr);
    f.blkoff = blkoff;
    f.bytoff = '0;
    return word_t'(f);
  endfunction

endpackage

// File: rtl/dcache_snoop_responder.sv
// Snoop responder inside each dcache: looks up a controller snoop in the
// 2-way tag/state arrays, flushes a dirty block over the dcache data port,
// then downgrades or invalidates the frame.
module dcache_snoop_responder
  import dcache_snoop_responder_pkg::*;
#(
  parameter int TAG_W = 26,
  parameter int IDX_W = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ccwait,
  input  logic             ccinv,
  input  logic [31:0]      ccsnoopaddr,
  input  logic             dwait,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  input  logic [1:0]       valid,
  input  logic [1:0]       dirty,
  input  logic [31:0]      blk_word0,
  input  logic [31:0]      blk_word1,
  output logic [IDX_W-1:0] snoop_idx,
  output logic             snoop_way,
  output logic             ccwrite,
  output logic             snoop_active,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  output logic             clr_dirty,
  output logic             clr_valid,
  output logic             snoop_done
);

  // Index field starts above the block and byte offsets.
  localparam int IDX_LSB = 3;

  snoop_state_t state, state_n;
  word_t        addr_q;
  logic         inv_q;
  logic         way_q;
  logic         dirty_q;

  logic         hit0, hit1, hit, hit_way, hit_dirty;

  // Tag compare against the latched snoop address; way 0 wins a double hit.
  always_comb begin
    hit0      = valid[0] && (tag0 == addr_q[31 -: TAG_W]);
    hit1      = valid[1] && (tag1 == addr_q[31 -: TAG_W]);
    hit       = hit0 || hit1;
    hit_way   = !hit0 && hit1;
    hit_dirty = hit && dirty[hit_way];
  end

  // State, latched snoop request and the looked-up way/dirty status.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_q  <= '0;
      inv_q   <= 1'b0;
      way_q   <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && ccwait) begin
        addr_q <= ccsnoopaddr;
        inv_q  <= ccinv;
      end
      if (state == LOOKUP) begin
        way_q   <= hit_way;
        dirty_q <= hit_dirty;
      end
    end
  end

  // Next-state sequencing of a snoop response.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ccwait) state_n = LOOKUP;
      LOOKUP: begin
        if (hit_dirty)      state_n = FLUSH0;
        else if (hit && inv_q) state_n = UPDATE;
        else                state_n = DONE;
      end
      FLUSH0:  if (!dwait) state_n = FLUSH1;
      FLUSH1:  if (!dwait) state_n = UPDATE;
      UPDATE:  state_n = DONE;
      DONE:    if (!ccwait) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode; the port path is driven only while flushing.
  always_comb begin
    snoop_active = (state == LOOKUP) || (state == FLUSH0) ||
                   (state == FLUSH1) || (state == UPDATE);
    ccwrite      = ((state == LOOKUP) && hit_dirty) ||
                   (state == FLUSH0) || (state == FLUSH1);
    dWEN         = (state == FLUSH0) || (state == FLUSH1);
    daddr        = '0;
    dstore       = '0;
    if (state == FLUSH0) begin
      daddr  = flush_addr(addr_q, 1'b0);
      dstore = blk_word0;
    end else if (state == FLUSH1) begin
      daddr  = flush_addr(addr_q, 1'b1);
      dstore = blk_word1;
    end
    clr_dirty  = (state == UPDATE) && dirty_q;
    clr_valid  = (state == UPDATE) && inv_q;
    snoop_done = (state == DONE);
    snoop_way  = (state == LOOKUP) ? hit_way : way_q;
    snoop_idx  = addr_q[IDX_LSB +: IDX_W];
  end

  // Both ways matching the same tag means the arrays are corrupt.
  a_single_hit : assert property (@(posedge CLK) disable iff (!nRST)
    (state == LOOKUP) |-> !(hit0 && hit1))
    else $error("snoop responder: both ways hit");

  // The controller must hold ccwait until the response completes.
  a_ccwait_held : assert property (@(posedge CLK) disable iff (!nRST)
    (state == LOOKUP || state == FLUSH0 || state == FLUSH1 || state == UPDATE)
      |-> ccwait)
    else $error("snoop responder: ccwait dropped before snoop_done");

endmodule

// File: tb/tb_dcache_snoop_responder.sv
module tb_dcache_snoop_responder;

  logic        CLK;
  logic        nRST;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dwait;
  logic [25:0] tag0, tag1;
  logic [1:0]  valid, dirty;
  logic [31:0] blk_word0, blk_word1;
  logic [2:0]  snoop_idx;
  logic        snoop_way;
  logic        ccwrite, snoop_active, dWEN;
  logic [31:0] daddr, dstore;
  logic        clr_dirty, clr_valid, snoop_done;

  // Cache array model, read at the responder's index/way.
  logic [25:0] tag_a   [2][8];
  logic        valid_a [2][8];
  logic        dirty_a [2][8];
  logic [31:0] w0_a    [2][8];
  logic [31:0] w1_a    [2][8];

  assign tag0      = tag_a[0][snoop_idx];
  assign tag1      = tag_a[1][snoop_idx];
  assign valid     = {valid_a[1][snoop_idx], valid_a[0][snoop_idx]};
  assign dirty     = {dirty_a[1][snoop_idx], dirty_a[0][snoop_idx]};
  assign blk_word0 = w0_a[snoop_way][snoop_idx];
  assign blk_word1 = w1_a[snoop_way][snoop_idx];

  dcache_snoop_responder #(.TAG_W(26), .IDX_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .tag0(tag0), .tag1(tag1),
    .valid(valid), .dirty(dirty), .blk_word0(blk_word0), .blk_word1(blk_word1),
    .snoop_idx(snoop_idx), .snoop_way(snoop_way), .ccwrite(ccwrite),
    .snoop_active(snoop_active), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .clr_dirty(clr_dirty), .clr_valid(clr_valid), .snoop_done(snoop_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        active;
    logic        ccwrite;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        clr_dirty;
    logic        clr_valid;
    logic        done;
    logic [2:0]  idx;
  } vec_t;

  typedef struct {
    vec_t v;
    logic chk_way;
    logic way;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t v_idle(input logic [2:0] idx);
    vec_t v;
    v     = '0;
    v.idx = idx;
    return v;
  endfunction

  function automatic vec_t v_lookup(input logic [2:0] idx, input logic ccw);
    vec_t v;
    v         = v_idle(idx);
    v.active  = 1'b1;
    v.ccwrite = ccw;
    return v;
  endfunction

  function automatic vec_t v_flush(input logic [2:0] idx, input logic [31:0] a,
                                   input logic [31:0] d);
    vec_t v;
    v         = v_lookup(idx, 1'b1);
    v.dwen    = 1'b1;
    v.daddr   = a;
    v.dstore  = d;
    return v;
  endfunction

  function automatic vec_t v_update(input logic [2:0] idx, input logic cd,
                                    input logic cv);
    vec_t v;
    v           = v_lookup(idx, 1'b0);
    v.clr_dirty = cd;
    v.clr_valid = cv;
    return v;
  endfunction

  function automatic vec_t v_done(input logic [2:0] idx);
    vec_t v;
    v      = v_idle(idx);
    v.done = 1'b1;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic chk_way, input logic way);
    exp_t e;
    e.v       = v;
    e.chk_way = chk_way;
    e.way     = way;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    vec_t o;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed output with no expected entry, required one queued", tag);
      return;
    end
    e = sb.pop_front();
    o.active    = snoop_active;
    o.ccwrite   = ccwrite;
    o.dwen      = dWEN;
    o.daddr     = daddr;
    o.dstore    = dstore;
    o.clr_dirty = clr_dirty;
    o.clr_valid = clr_valid;
    o.done      = snoop_done;
    o.idx       = snoop_idx;
    assert (o === e.v) else begin
      n_err++;
      $error("FAIL %s: observed %p required %p", tag, o, e.v);
    end
    if (e.chk_way) begin
      n_vec++;
      assert (snoop_way === e.way) else begin
        n_err++;
        $error("FAIL %s_way: observed %b required %b", tag, snoop_way, e.way);
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge CLK);
    check_now(tag);
  endtask

  // Way 1 of set 2 holds a dirty block with tag 1; way 0 a dirty non-matching block.
  task automatic setup_set2();
    tag_a[1][2] = 26'h1; valid_a[1][2] = 1'b1; dirty_a[1][2] = 1'b1;
    w0_a[1][2]  = 32'hDEAD_BEEF; w1_a[1][2] = 32'hCAFE_F00D;
    tag_a[0][2] = 26'h5; valid_a[0][2] = 1'b1; dirty_a[0][2] = 1'b1;
    w0_a[0][2]  = 32'h1111_1111; w1_a[0][2] = 32'h2222_2222;
  endtask

  task automatic dirty_hit(input logic [31:0] addr, input logic inv, input string tag);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF8;
    setup_set2();
    ccsnoopaddr = addr; ccinv = inv; ccwait = 1'b1;
    push(v_lookup(3'd2, 1'b1), 1'b1, 1'b1);
    push(v_flush(3'd2, base, 32'hDEAD_BEEF), 1'b1, 1'b1);
    push(v_flush(3'd2, base + 32'd4, 32'hCAFE_F00D), 1'b1, 1'b1);
    push(v_update(3'd2, 1'b1, inv), 1'b1, 1'b1);
    push(v_done(3'd2), 1'b0, 1'b0);
    repeat (5) cycle(tag);
    ccwait = 1'b0; ccinv = 1'b0;
    push(v_idle(3'd2), 1'b0, 1'b0);
    cycle({tag, "_idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0; dwait = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        tag_a[w][s] = '0; valid_a[w][s] = 1'b0; dirty_a[w][s] = 1'b0;
        w0_a[w][s] = '0; w1_a[w][s] = '0;
      end

    // Reset state
    push(v_idle(3'd0), 1'b1, 1'b0);
    #1 check_now("reset_async");
    @(negedge CLK);
    nRST = 1'b1;
    push(v_idle(3'd0), 1'b1, 1'b0);
    cycle("reset_idle");

    // Miss; ccwait held an extra cycle keeps snoop_done up
    ccsnoopaddr = 32'h0000_0040; ccwait = 1'b1;
    push(v_lookup(3'd0, 1'b0), 1'b0, 1'b0);
    push(v_done(3'd0), 1'b0, 1'b0);
    push(v_done(3'd0), 1'b0, 1'b0);
    repeat (3) cycle("miss");
    ccwait = 1'b0;
    push(v_idle(3'd0), 1'b0, 1'b0);
    cycle("miss_idle");

    // Dirty read hit, then dirty BusRdX hit on the upper word of the block
    dirty_hit(32'h0000_0050, 1'b0, "dirty_rd");
    dirty_hit(32'h0000_0054, 1'b1, "dirty_inv");

    // Clean BusRdX hit in way 0; way 1 is valid, dirty but a different tag
    tag_a[0][3] = 26'h3FF_FFFF; valid_a[0][3] = 1'b1; dirty_a[0][3] = 1'b0;
    tag_a[1][3] = 26'h0;        valid_a[1][3] = 1'b1; dirty_a[1][3] = 1'b1;
    ccsnoopaddr = 32'hFFFF_FFD8; ccinv = 1'b1; ccwait = 1'b1;
    push(v_lookup(3'd3, 1'b0), 1'b1, 1'b0);
    push(v_update(3'd3, 1'b0, 1'b1), 1'b1, 1'b0);
    push(v_done(3'd3), 1'b0, 1'b0);
    repeat (3) cycle("clean_inv");
    ccwait = 1'b0; ccinv = 1'b0;
    push(v_idle(3'd3), 1'b0, 1'b0);
    cycle("clean_inv_idle");

    // Clean read hit; ccinv rising after the snoop is latched is ignored
    ccsnoopaddr = 32'hFFFF_FFD8; ccinv = 1'b0; ccwait = 1'b1;
    push(v_lookup(3'd3, 1'b0), 1'b1, 1'b0);
    push(v_done(3'd3), 1'b0, 1'b0);
    cycle("clean_rd");
    ccinv = 1'b1;
    cycle("clean_rd");
    ccwait = 1'b0; ccinv = 1'b0;
    push(v_idle(3'd3), 1'b0, 1'b0);
    cycle("clean_rd_idle");

    // dwait stall for 4 cycles in FLUSH0
    setup_set2();
    dwait = 1'b1;
    ccsnoopaddr = 32'h0000_0050; ccwait = 1'b1;
    push(v_lookup(3'd2, 1'b1), 1'b1, 1'b1);
    repeat (4) push(v_flush(3'd2, 32'h50, 32'hDEAD_BEEF), 1'b1, 1'b1);
    push(v_flush(3'd2, 32'h54, 32'hCAFE_F00D), 1'b1, 1'b1);
    push(v_update(3'd2, 1'b1, 1'b0), 1'b1, 1'b1);
    push(v_done(3'd2), 1'b0, 1'b0);
    repeat (5) cycle("stall");
    dwait = 1'b0;
    repeat (3) cycle("stall");
    ccwait = 1'b0;
    push(v_idle(3'd2), 1'b0, 1'b0);
    cycle("stall_idle");

    // Reset asserted in FLUSH1
    setup_set2();
    ccsnoopaddr = 32'h0000_0050; ccwait = 1'b1;
    push(v_lookup(3'd2, 1'b1), 1'b1, 1'b1);
    push(v_flush(3'd2, 32'h50, 32'hDEAD_BEEF), 1'b1, 1'b1);
    push(v_flush(3'd2, 32'h54, 32'hCAFE_F00D), 1'b1, 1'b1);
    repeat (3) cycle("rst_pre");
    #2 nRST = 1'b0; ccwait = 1'b0;
    push(v_idle(3'd0), 1'b1, 1'b0);
    #1 check_now("rst_async_flush1");
    push(v_idle(3'd0), 1'b1, 1'b0);
    cycle("rst_hold");
    nRST = 1'b1;
    push(v_idle(3'd0), 1'b1, 1'b0);
    cycle("rst_release");
    dirty_hit(32'h0000_0050, 1'b0, "restart");

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: observed %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
